// File: rtl/button_conditioner.sv
// Push-button conditioner: synchroniser, debouncer, press/release strobes.
// Define BUTTON_LONG_PRESS_EN to build the hold counter that drives long_o.
module button_conditioner #(
  parameter int DEBOUNCE_COUNT = 300000,
  parameter int LONG_COUNT     = 30000000 - 1,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic button_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int DW = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_COUNT - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          pressed_raw;

  assign pressed_raw = ACTIVE_LOW ? ~button_i : button_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_cnt_q  <= db_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Any cycle where the synchronised pin agrees with the state discards the partial count.
  always_comb begin
    sync1_d   = pressed_raw;
    sync2_d   = sync1_q;
    state_d   = state_q;
    db_cnt_d  = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          if (db_cnt_q == DB_LAST) begin
            state_d = PRESSED;
            press_d = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + DW'(1);
          end
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          if (db_cnt_q == DB_LAST) begin
            state_d   = IDLE;
            release_d = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + DW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level_o   = (state_q == PRESSED);
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BUTTON_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_COUNT + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_COUNT - 1);
  localparam logic [LW-1:0] LONG_FULL = LW'(LONG_COUNT);

  logic [LW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  // The counter parks at LONG_COUNT so a single hold yields a single pulse.
  always_comb begin
    hold_d = '0;
    long_d = 1'b0;
    if (state_q == PRESSED) begin
      long_d = (hold_q == LONG_LAST);
      hold_d = (hold_q == LONG_FULL) ? hold_q : hold_q + LW'(1);
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule
